shift_seq_engine: RTL and testbench

SHIFT_SEQ_ENGINE -- requirements
Module: shift_seq_engine

---
 rtl/shift_seq_engine.sv | 161 ++++++++++++++++
 tb/tb_shift_seq_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_engine.sv
// -----------------------------------------------------------------------------
// shift_seq_engine
//   Sequenced shift/rotate register. A start request either completes at once
//   (NOP, LOAD, CLR, or any shift/rotate with a zero count) or launches a
//   multi-cycle run that performs one 1-bit shift/rotate per clock until the
//   latched count is exhausted, then pulses done for one cycle.
//
// Ports
//   clk    : single clock, all state changes on the rising edge
//   reset  : asynchronous active-low reset
//   start  : begin a new operation (honoured in IDLE or DONE only)
//   op     : opcode, sampled on the accepted start
//   amt    : shift count, sampled on the accepted start
//   d      : parallel load data
//   sin    : serial fill bit for SHL/SHR, sampled on every shift edge
//   q      : register contents
//   so     : last bit shifted or rotated out of q
//   busy   : high while a multi-cycle run is in progress
//   done   : one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_seq_engine #(
    parameter int N  = 8,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [SW-1:0] amt,
    input  logic [N-1:0]  d,
    input  logic          sin,
    output logic [N-1:0]  q,
    output logic          so,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_SAR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    state_t        state, state_nx;
    op_t           op_r, op_r_nx;
    op_t           op_in;
    logic [SW-1:0] cnt, cnt_nx;
    logic [N-1:0]  q_nx;
    logic          so_nx;
    logic [N-1:0]  shift_q;
    logic          shift_out;

    assign op_in = op_t'(op);

    // One 1-bit step of the latched operation applied to the current q.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        shift_q   = q;
        shift_out = 1'b0;
        case (op_r)
            OP_SHL: begin
                shift_q   = {q[N-2:0], sin};
                shift_out = q[N-1];
            end
            OP_SHR: begin
                shift_q   = {sin, q[N-1:1]};
                shift_out = q[0];
            end
            OP_SAR: begin
                shift_q   = {q[N-1], q[N-1:1]};
                shift_out = q[0];
            end
            OP_ROL: begin
                shift_q   = {q[N-2:0], q[N-1]};
                shift_out = q[N-1];
            end
            OP_ROR: begin
                shift_q   = {q[0], q[N-1:1]};
                shift_out = q[0];
            end
            default: ;
        endcase
    end

    // Next-state and datapath next values.
    always_comb begin
        state_nx = state;
        op_r_nx  = op_r;
        cnt_nx   = cnt;
        q_nx     = q;
        so_nx    = so;
        case (state)
            RUN: begin
                // start is deliberately not looked at here: requests during a
                // run are dropped, not queued.
                q_nx   = shift_q;
                so_nx  = shift_out;
                cnt_nx = cnt - SW'(1);
                if (cnt == SW'(1)) begin
                    state_nx = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a request; DONE falls back to IDLE
                // when none arrives, so it never lasts more than one cycle.
                state_nx = IDLE;
                if (start) begin
                    state_nx = DONE;
                    case (op_in)
                        OP_NOP:  ;
                        OP_LOAD: q_nx = d;
                        OP_CLR:  q_nx = '0;
                        default: begin
                            // A zero count completes immediately with q and so
                            // untouched.
                            if (amt != '0) begin
                                op_r_nx  = op_in;
                                cnt_nx   = amt;
                                state_nx = RUN;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state <= IDLE;
            op_r  <= OP_NOP;
            cnt   <= '0;
            q     <= '0;
            so    <= 1'b0;
        end else begin
            state <= state_nx;
            op_r  <= op_r_nx;
            cnt   <= cnt_nx;
            q     <= q_nx;
            so    <= so_nx;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_seq_engine.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_engine
//   Directed bench for shift_seq_engine. A transaction-level model (remaining
//   step count plus arithmetic shift/rotate expressions) predicts q, so, busy
//   and done; a compare process checks them on every falling edge while out of
//   reset, and the stimulus sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_shift_seq_engine;

    localparam int N  = 8;
    localparam int SW = 4;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] SAR  = 3'b100;
    localparam logic [2:0] ROL  = 3'b101;
    localparam logic [2:0] ROR  = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op    = 3'b000;
    logic [SW-1:0] amt   = '0;
    logic [N-1:0]  d     = '0;
    logic          sin   = 1'b0;
    logic [N-1:0]  q;
    logic          so;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    shift_seq_engine #(.N(N), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .amt   (amt),
        .d     (d),
        .sin   (sin),
        .q     (q),
        .so    (so),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] model_step(input logic [2:0] o, input logic [N-1:0] v,
                                                input logic s);
        case (o)
            SHL:     return N'(v << 1) | N'(s);
            SHR:     return N'(v >> 1) | (N'(s) << (N - 1));
            SAR:     return N'($signed(v) >>> 1);
            ROL:     return N'(v << 1) | N'(v >> (N - 1));
            ROR:     return N'(v >> 1) | N'(v << (N - 1));
            default: return v;
        endcase
    endfunction

    function automatic logic model_out(input logic [2:0] o, input logic [N-1:0] v);
        if (o == SHL || o == ROL) return v[N-1];
        return v[0];
    endfunction

    logic [N-1:0] m_q    = '0;
    logic         m_so   = 1'b0;
    logic [2:0]   m_op   = 3'b000;
    int           m_rem  = 0;
    logic         m_done = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q    <= '0;
            m_so   <= 1'b0;
            m_rem  <= 0;
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            m_q    <= model_step(m_op, m_q, sin);
            m_so   <= model_out(m_op, m_q);
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
        end else begin
            m_done <= 1'b0;
            if (start) begin
                if (op == NOP || op == LOAD || op == CLR || amt == '0) begin
                    if (op == LOAD) m_q <= d;
                    if (op == CLR)  m_q <= '0;
                    m_done <= 1'b1;
                end else begin
                    m_op  <= op;
                    m_rem <= int'(amt);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("q",    q,    m_q);
            check("so",   so,   m_so);
            check("busy", busy, m_rem > 0);
            check("done", done, m_done);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [2:0] o, input int a, input logic [N-1:0] dv, input logic s);
        op    = o;
        amt   = SW'(a);
        d     = dv;
        sin   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // n0 is the cycle count already elapsed since the start edge, inclusive.
    task automatic wait_done(input string name, input int n0, input int exp_lat);
        int n = n0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_q",    q,    8'h00);
        check("rst_so",   so,   1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        // Abort a running SHL with reset between edges.
        reset = 1'b1;
        @(negedge clk);
        issue(SHL, 5, 8'h00, 1'b1);
        @(negedge clk);
        check("pre_abort_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("abort_q",    q,    8'h00);
        check("abort_so",   so,   1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        issue(LOAD, 0, 8'h3C, 1'b0);
        check("load3c_q",    q,    8'h3C);
        check("load3c_done", done, 1'b1);
        @(negedge clk);

        // LOAD A5: one-cycle done, never busy.
        issue(LOAD, 0, 8'hA5, 1'b0);
        check("loada5_q",    q,    8'hA5);
        check("loada5_done", done, 1'b1);
        check("loada5_busy", busy, 1'b0);
        @(negedge clk);
        check("loada5_done_off", done, 1'b0);

        // SHL 3 with sin=1, plus an ignored LOAD request mid-run.
        issue(SHL, 3, 8'h00, 1'b1);
        op    = LOAD;
        d     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("shl3_lat", 2, 4);
        check("shl3_q",  q,  8'h2F);
        check("shl3_so", so, 1'b1);
        @(negedge clk);

        // SAR then long SHR.
        issue(LOAD, 0, 8'h96, 1'b0);
        issue(SAR, 2, 8'h00, 1'b0);
        wait_done("sar2_lat", 1, 3);
        check("sar2_q",  q,  8'hE5);
        check("sar2_so", so, 1'b1);
        @(negedge clk);
        issue(SHR, 10, 8'h00, 1'b0);
        wait_done("shr10_lat", 1, 11);
        check("shr10_q", q, 8'h00);
        @(negedge clk);

        // ROR wraps; ROL by zero completes at once, so unchanged.
        issue(LOAD, 0, 8'h81, 1'b0);
        issue(ROR, 9, 8'h00, 1'b0);
        wait_done("ror9_lat", 1, 10);
        check("ror9_q",  q,  8'hC0);
        check("ror9_so", so, 1'b1);
        issue(ROL, 0, 8'h00, 1'b0);
        check("rol0_q",    q,    8'hC0);
        check("rol0_so",   so,   1'b1);
        check("rol0_done", done, 1'b1);
        @(negedge clk);

        // Back-to-back: start held through DONE.
        op    = LOAD;
        d     = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        check("b2b_load_q",    q,    8'h0F);
        check("b2b_load_done", done, 1'b1);
        op = CLR;
        @(negedge clk);
        check("b2b_clr_q",    q,    8'h00);
        check("b2b_clr_done", done, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check("b2b_done_off", done, 1'b0);

        // Counts beyond N.
        issue(SHL, 12, 8'h00, 1'b1);
        wait_done("shl12_lat", 1, 13);
        check("shl12_q", q, 8'hFF);
        @(negedge clk);
        issue(LOAD, 0, 8'h80, 1'b0);
        issue(SAR, 15, 8'h00, 1'b0);
        wait_done("sar15_lat", 1, 16);
        check("sar15_q", q, 8'hFF);
        @(negedge clk);
        issue(LOAD, 0, 8'h81, 1'b0);
        issue(ROL, 11, 8'h00, 1'b0);
        wait_done("rol11_lat", 1, 12);
        check("rol11_q", q, 8'h0C);
        @(negedge clk);

        // NOP leaves q alone.
        issue(NOP, 3, 8'hFF, 1'b0);
        check("nop_q",    q,    8'h0C);
        check("nop_done", done, 1'b1);
        @(negedge clk);

        // sin sampled live on each shift edge: 1,0,1,1.
        issue(CLR, 0, 8'h00, 1'b0);
        issue(SHL, 4, 8'h00, 1'b0);
        sin = 1'b1;
        @(negedge clk);
        sin = 1'b0;
        @(negedge clk);
        sin = 1'b1;
        @(negedge clk);
        sin = 1'b1;
        @(negedge clk);
        check("sin_live_q",    q,    8'h0B);
        check("sin_live_done", done, 1'b1);
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
